// File: rtl/ieee754_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (A - B) with valid/ready handshake.
// Define GUARD_ROUND_EN for guard/round/sticky tracking and round-to-nearest-even; otherwise truncates.
module ieee754_sub_seq #(
    parameter int ALIGN_STEP = 1,
    parameter int NORM_STEP  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  flags
);

`ifdef GUARD_ROUND_EN
    localparam int GX = 3;
`else
    localparam int GX = 0;
`endif
    // Mantissa layout: [C] carry, [H] hidden bit, [GX-1:0] guard/round/sticky.
    localparam int MW = 25 + GX;
    localparam int H  = 23 + GX;
    localparam int C  = 24 + GX;
    localparam logic [4:0]  ASTEP = 5'(ALIGN_STEP);
    localparam logic [4:0]  NSTEP = 5'(NORM_STEP);
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ARITH,
        S_NORM,
`ifdef GUARD_ROUND_EN
        S_ROUND,
`endif
        S_DONE
    } state_t;

    state_t      state_q;
    logic        in_ready_q, out_valid_q;
    logic [31:0] result_q;
    logic [3:0]  flags_q;
    logic [31:0] a_q, b_q;
    logic        sx_q, sy_q;
    logic [8:0]  ex_q;
    logic [MW-1:0] mx_q, my_q;
    logic [4:0]  d_q;

    logic [7:0]  ea, eb, ea_eff, eb_eff, diff;
    logic [22:0] fa, fb;
    logic [23:0] ma, mb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
    logic [4:0]  d_clamp;

    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign fa     = a_q[22:0];
    assign fb     = b_q[22:0];
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_zero = (ea == 8'd0) && (fa == 23'd0);
    assign b_zero = (eb == 8'd0) && (fb == 23'd0);
    assign ea_eff = (ea == 8'd0) ? 8'd1 : ea;
    assign eb_eff = (eb == 8'd0) ? 8'd1 : eb;
    assign ma     = {(ea != 8'd0), fa};
    assign mb     = {(eb != 8'd0), fb};
    assign a_big  = {ea_eff, ma} >= {eb_eff, mb};
    assign diff   = a_big ? (ea_eff - eb_eff) : (eb_eff - ea_eff);
    assign d_clamp = (diff > 8'd26) ? 5'd26 : diff[4:0];

    logic [4:0]    a_step_d, n_step_d, lz_d;
    logic [MW-1:0] align_d, sum_d;
    logic [8:0]    exp_inc_d;

    assign a_step_d  = (d_q < ASTEP) ? d_q : ASTEP;
    assign sum_d     = (sx_q == sy_q) ? (mx_q + my_q) : (mx_q - my_q);
    assign exp_inc_d = ex_q + 9'd1;
    assign n_step_d  = (lz_d < NSTEP) ? lz_d : NSTEP;

    always_comb begin
        align_d = my_q >> a_step_d;
`ifdef GUARD_ROUND_EN
        align_d[0] = align_d[0] | (|(my_q & ((MW'(1) << a_step_d) - MW'(1))));
`endif
    end

    // Leading zeros counted from the hidden-bit position downward.
    always_comb begin
        lz_d = 5'(H + 1);
        for (int i = 0; i <= H; i++) begin
            if (mx_q[i]) lz_d = 5'(H - i);
        end
    end

`ifdef GUARD_ROUND_EN
    logic [MW-1:0] rsh_d;
    logic          rnd_up_d;
    logic [23:0]   rnd_d;
    assign rsh_d    = {1'b0, mx_q[MW-1:2], mx_q[1] | mx_q[0]};
    assign rnd_up_d = mx_q[2] & (mx_q[1] | mx_q[0] | mx_q[3]);
    assign rnd_d    = {1'b0, mx_q[H-1:GX]} + 24'(rnd_up_d);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            flags_q     <= 4'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            ex_q        <= 9'd0;
            mx_q        <= '0;
            my_q        <= '0;
            d_q         <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= {~b[31], b[30:0]};
                        in_ready_q <= 1'b0;
                        state_q    <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                    flags_q     <= 4'b0000;
                    if (a_nan || b_nan) begin
                        result_q <= QNAN;
                        flags_q  <= 4'b1000;
                    end else if (a_inf && b_inf && (a_q[31] != b_q[31])) begin
                        // b_q carries the flipped sign, so differing bits mean equal original signs.
                        result_q <= QNAN;
                        flags_q  <= 4'b1000;
                    end else if (a_inf) begin
                        result_q <= a_q;
                    end else if (b_inf) begin
                        result_q <= b_q;
                    end else if (a_zero && b_zero) begin
                        result_q <= {a_q[31] & b_q[31], 31'd0};
                        flags_q  <= 4'b0001;
                    end else if (a_zero) begin
                        result_q <= b_q;
                    end else if (b_zero) begin
                        result_q <= a_q;
                    end else begin
                        out_valid_q <= 1'b0;
                        sx_q <= a_big ? a_q[31] : b_q[31];
                        sy_q <= a_big ? b_q[31] : a_q[31];
                        ex_q <= {1'b0, a_big ? ea_eff : eb_eff};
                        mx_q <= MW'(a_big ? ma : mb) << GX;
                        my_q <= MW'(a_big ? mb : ma) << GX;
                        d_q  <= d_clamp;
                        state_q <= (d_clamp == 5'd0) ? S_ARITH : S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    my_q <= align_d;
                    d_q  <= d_q - a_step_d;
                    if (d_q == a_step_d) state_q <= S_ARITH;
                end
                S_ARITH: begin
                    if (sum_d == '0) begin
                        result_q    <= 32'd0;
                        flags_q     <= 4'b0001;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        mx_q    <= sum_d;
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (mx_q[C]) begin
                        if (exp_inc_d == 9'd255) begin
                            result_q    <= {sx_q, 8'hFF, 23'd0};
                            flags_q     <= 4'b0100;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
`ifdef GUARD_ROUND_EN
                            mx_q    <= rsh_d;
                            ex_q    <= exp_inc_d;
                            state_q <= S_ROUND;
`else
                            result_q    <= {sx_q, exp_inc_d[7:0], mx_q[H:GX+1]};
                            flags_q     <= 4'b0000;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
`endif
                        end
                    end else if (mx_q[H]) begin
`ifdef GUARD_ROUND_EN
                        state_q <= S_ROUND;
`else
                        result_q    <= {sx_q, ex_q[7:0], mx_q[H-1:GX]};
                        flags_q     <= 4'b0000;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
`endif
                    end else if (ex_q <= {4'd0, n_step_d}) begin
                        // Results below the normal range flush to a signed zero.
                        result_q    <= {sx_q, 31'd0};
                        flags_q     <= 4'b0011;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        mx_q <= mx_q << n_step_d;
                        ex_q <= ex_q - {4'd0, n_step_d};
                    end
                end
`ifdef GUARD_ROUND_EN
                S_ROUND: begin
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                    flags_q     <= 4'b0000;
                    if (rnd_d[23]) begin
                        if (exp_inc_d == 9'd255) begin
                            result_q <= {sx_q, 8'hFF, 23'd0};
                            flags_q  <= 4'b0100;
                        end else begin
                            result_q <= {sx_q, exp_inc_d[7:0], 23'd0};
                        end
                    end else begin
                        result_q <= {sx_q, ex_q[7:0], rnd_d[22:0]};
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_ieee754_sub_seq.sv
// Scoreboard bench for ieee754_sub_seq: driver pushes hand-computed expectations, monitor pops on output.
module tb_ieee754_sub_seq;

`ifdef GUARD_ROUND_EN
    localparam int R = 1;
    localparam int CLAMP_LAT = 32;
`else
    localparam int R = 0;
    localparam int CLAMP_LAT = 30;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  flags;

    ieee754_sub_seq #(.ALIGN_STEP(1), .NORM_STEP(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, req);
    endtask

    // Monitor: tracks handshake and first-valid cycles, compares on output acceptance.
    int  hs_cyc = 0;
    int  first_cyc = 0;
    bit  seen = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
            end else begin
                if (in_valid && in_ready) hs_cyc = cyc;
                if (out_valid && !seen) begin
                    first_cyc = cyc;
                    seen = 1;
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_output: got result %h flags %b, required no output", result, flags);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk({e.name, " result"}, result, e.res);
                        chk({e.name, " flags"}, {28'd0, flags}, {28'd0, e.flg});
                        chk({e.name, " latency"}, first_cyc - hs_cyc, e.lat);
                        $display("txn %-14s result=%h flags=%b latency=%0d", e.name, result, flags, first_cyc - hs_cyc);
                    end
                    seen = 0;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input string nm);
        int w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk({nm, " in_ready_wait"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input string nm, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] res, input logic [3:0] flg, input int lat, input int hold);
        exp_t e;
        int w;
        e.name = nm; e.res = res; e.flg = flg; e.lat = lat;
        sb_q.push_back(e);
        if (hold > 0) out_ready = 1'b0;
        issue(av, bv, nm);
        if (hold > 0) begin
            w = 0;
            while (!out_valid && w < 200) begin
                @(posedge clk); #1;
                w++;
            end
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk({nm, " hold_valid"}, {31'd0, out_valid}, 32'd1);
                chk({nm, " hold_result"}, result, res);
                chk({nm, " hold_flags"}, {28'd0, flags}, {28'd0, flg});
                chk({nm, " hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
        end
        w = 0;
        do begin
            @(posedge clk); #1;
            w++;
        end while (sb_q.size() != 0 && w < 500);
        chk({nm, " completion"}, sb_q.size(), 32'd0);
        if (hold > 0) begin
            chk({nm, " post_accept_valid"}, {31'd0, out_valid}, 32'd0);
            chk({nm, " post_accept_in_ready"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_v;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset flags", {28'd0, flags}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        send("3-1",       32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0000, 5 + R, 0);
        send("1-1",       32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4'b0001, 3, 0);
        send("-0-+0",     32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 4'b0001, 2, 0);
        send("+0--0",     32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0001, 2, 0);
        send("inf-inf",   32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000, 2, 0);
        send("nan-1",     32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 2, 0);
        send("max--max",  32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4'b0100, 4, 0);
        send("inf-1",     32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 4'b0000, 2, 0);
        send("1-inf",     32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 4'b0000, 2, 0);
        send("inf--inf",  32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000, 4'b0000, 2, 0);
        send("0-1",       32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 4'b0000, 2, 0);
        send("1-0",       32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 4'b0000, 2, 0);
        send("1-3",       32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 4'b0000, 5 + R, 0);
        send("-1-1",      32'hBF80_0000, 32'h3F80_0000, 32'hC000_0000, 4'b0000, 4 + R, 0);
        send("1.5-1",     32'h3FC0_0000, 32'h3F80_0000, 32'h3F00_0000, 4'b0000, 5 + R, 0);
        send("minnorm-sub", 32'h0080_0000, 32'h0000_0001, 32'h0000_0000, 4'b0011, 4, 0);
        send("1-2^-30",   32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000, 4'b0000, CLAMP_LAT, 0);
        send("5-3 hold",  32'h40A0_0000, 32'h4040_0000, 32'h4000_0000, 4'b0000, 6 + R, 5);

        // Abort an operation mid-ALIGN; nothing may be emitted for it.
        issue(32'h3F80_0000, 32'h3580_0000, "abort");
        repeat (8) @(posedge clk);
        #1;
        chk("abort pre_reset out_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;
        #1;
        chk("abort in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        any_v = 0;
        repeat (30) begin
            @(negedge clk);
            any_v |= out_valid;
        end
        chk("abort no_output", {31'd0, any_v}, 32'd0);
        @(posedge clk); #1;
        send("2-0.5",     32'h4000_0000, 32'h3F00_0000, 32'h3FC0_0000, 4'b0000, 7 + R, 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
